// File: rtl/uart_rx_sampler_if.sv
// rtl/uart_rx_sampler_if.sv - serial input, tick and receive-result bundle for uart_rx_sampler
// slave is the receiver side; master is the BRG/line/consumer side.
interface uart_rx_sampler_if #(
  parameter int DATA_BITS = 8
);
  logic                 baud_tick;
  logic                 UxRX;
  logic                 ABAUD;
  logic                 rd;
  logic [DATA_BITS-1:0] rx_data;
  logic                 UxRXIF;
  logic                 FERR;
  logic                 OERR;
  logic                 PERR;
  logic                 busy;

  modport master (
    output baud_tick, UxRX, ABAUD, rd,
    input  rx_data, UxRXIF, FERR, OERR, PERR, busy
  );

  modport slave (
    input  baud_tick, UxRX, ABAUD, rd,
    output rx_data, UxRXIF, FERR, OERR, PERR, busy
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - oversampling 8N1 deframer downstream of the auto-baud BRG
// Define UART_RX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_rx_sampler #(
  parameter int OVS       = 16,
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 6
) (
  input logic            clk,
  input logic            rst,
  uart_rx_sampler_if.slave bus
);

  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVS / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVS - 1);
  localparam logic [BIT_W-1:0] IDX_LAST  = BIT_W'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [BIT_W-1:0]     idx_q;
  logic                 sync1_q;
  logic                 rxs_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rxif_q;
  logic                 ferr_q;
  logic                 oerr_q;
  logic                 busy_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_err_q;
  logic                 perr_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      sync1_q   <= 1'b1;
      rxs_q     <= 1'b1;
      shift_q   <= '0;
      rx_data_q <= '0;
      rxif_q    <= 1'b0;
      ferr_q    <= 1'b0;
      oerr_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      sync1_q <= bus.UxRX;
      rxs_q   <= sync1_q;

      if (bus.rd) begin
        rxif_q <= 1'b0;
        ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_q <= 1'b0;
`endif
      end

      // Auto-baud owns the line: park the deframer, keep delivered data and flags.
      if (bus.ABAUD) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        idx_q   <= '0;
        busy_q  <= 1'b0;
      end else if (bus.baud_tick) begin
        case (state_q)
          S_IDLE: begin
            if (!rxs_q) begin
              state_q <= S_START;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end
          end

          S_START: begin
            if (cnt_q == HALF_LAST) begin
              cnt_q <= '0;
              idx_q <= '0;
              if (rxs_q) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= S_DATA;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end

          S_DATA: begin
            if (cnt_q == BIT_LAST) begin
              cnt_q   <= '0;
              shift_q <= {rxs_q, shift_q[DATA_BITS-1:1]};
              if (idx_q == IDX_LAST) begin
                idx_q <= '0;
`ifdef UART_RX_PARITY_EN
                state_q <= S_PARITY;
`else
                state_q <= S_STOP;
`endif
              end else begin
                idx_q <= idx_q + BIT_W'(1);
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end

`ifdef UART_RX_PARITY_EN
          S_PARITY: begin
            if (cnt_q == BIT_LAST) begin
              cnt_q     <= '0;
              par_err_q <= (^shift_q) ^ rxs_q;
              state_q   <= S_STOP;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
`endif

          S_STOP: begin
            if (cnt_q == BIT_LAST) begin
              cnt_q   <= '0;
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              // A read in the completion cycle frees the holding register, so no overrun.
              if (!rxif_q || bus.rd) begin
                rx_data_q <= shift_q;
                rxif_q    <= 1'b1;
                ferr_q    <= ~rxs_q;
`ifdef UART_RX_PARITY_EN
                perr_q    <= par_err_q;
`endif
              end else begin
                oerr_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end

          default: begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rx_data = rx_data_q;
  assign bus.UxRXIF  = rxif_q;
  assign bus.FERR    = ferr_q;
  assign bus.OERR    = oerr_q;
  assign bus.busy    = busy_q;
`ifdef UART_RX_PARITY_EN
  assign bus.PERR    = perr_q;
`else
  assign bus.PERR    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb/tb_uart_rx_sampler.sv - directed frames against a frame-level receive model
// Honours UART_RX_PARITY_EN to add the parity bit and a parity-error frame.
module tb_uart_rx_sampler;

  localparam int OVS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  localparam int NBITS = 10 + NPAR;
  // Line fall sampled on edge 0, rxs low after edge 1, START entered on edge 2.
  localparam int DONE_AT = 2 + OVS / 2 + OVS * (8 + 1 + NPAR);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic presc = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic mdl_on = 1'b0;

  logic [7:0] m_data;
  logic       m_rxif, m_ferr, m_oerr, m_perr;

  uart_rx_sampler_if #(.DATA_BITS(8)) bus ();

  uart_rx_sampler #(.OVS(OVS), .DATA_BITS(8), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    m_data = 8'h00; m_rxif = 1'b0; m_ferr = 1'b0; m_oerr = 1'b0; m_perr = 1'b0;
  endtask

  task automatic mdl_frame(input logic [7:0] d, input logic stop_b, input logic par_flip,
                           input logic rd_same);
    if (!m_rxif || rd_same) begin
      m_data = d;
      m_rxif = 1'b1;
      m_ferr = ~stop_b;
      m_perr = (NPAR == 1) ? par_flip : 1'b0;
    end else begin
      m_oerr = 1'b1;
    end
  endtask

  initial begin
    int tph;
    tph = 0;
    bus.baud_tick = 1'b1;
    forever begin
      @(negedge clk);
      if (presc) begin
        bus.baud_tick = (tph == 0);
        tph = (tph + 1) % 4;
      end else begin
        bus.baud_tick = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (mdl_on) begin
        chk("rx_data", 32'(bus.rx_data), 32'(m_data));
        chk("UxRXIF", 32'(bus.UxRXIF), 32'(m_rxif));
        chk("FERR", 32'(bus.FERR), 32'(m_ferr));
        chk("OERR", 32'(bus.OERR), 32'(m_oerr));
        chk("PERR", 32'(bus.PERR), 32'(m_perr));
      end
    end
  end

  task automatic do_rd();
    bus.rd = 1'b1;
    m_rxif = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
    @(negedge clk);
    bus.rd = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.UxRX = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; n counts negedges from the start-bit drive.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip,
                            input int bit_cyc, input int done_at, input logic rd_same,
                            input int abort_at, input int rst_at);
    logic [11:0] bits;
    int n;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
    if (NPAR == 1) bits[9] = (^d) ^ par_flip;
    bits[NBITS - 1] = stop_b;
    n = 0;
    for (int b = 0; b < NBITS; b++) begin
      bus.UxRX = bits[b];
      for (int c = 0; c < bit_cyc; c++) begin
        if (n == done_at) begin
          mdl_frame(d, stop_b, par_flip, rd_same);
          if (rd_same) bus.rd = 1'b1;
        end
        if (rd_same && n == done_at + 1) bus.rd = 1'b0;
        if (n == abort_at) bus.ABAUD = 1'b1;
        if (abort_at >= 0 && n == abort_at + 1) chk("abaud_busy", 32'(bus.busy), 32'h0);
        if (n == rst_at) begin
          rst = 1'b1;
          mdl_reset();
        end
        if (rst_at >= 0 && n == rst_at + 1) begin
          rst = 1'b0;
          chk("rst_busy", 32'(bus.busy), 32'h0);
        end
        @(negedge clk);
        n++;
      end
    end
    bus.UxRX = 1'b1;
  endtask

  initial begin
    logic saw_busy;
    bus.UxRX = 1'b1;
    bus.ABAUD = 1'b0;
    bus.rd = 1'b0;
    mdl_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mdl_on = 1'b1;
    chk("reset_busy", 32'(bus.busy), 32'h0);
    chk("reset_data", 32'(bus.rx_data), 32'h0);
    idle(5);

    // Basic receive; completion edge pinned by DONE_AT
    send_frame(8'h55, 1'b1, 1'b0, OVS, DONE_AT, 1'b0, -1, -1);
    chk("basic_data", 32'(bus.rx_data), 32'h55);
    chk("basic_ferr", 32'(bus.FERR), 32'h0);
    chk("basic_rxif", 32'(bus.UxRXIF), 32'h1);
    do_rd();
    chk("basic_rd_rxif", 32'(bus.UxRXIF), 32'h0);
    idle(20);

    // Glitch shorter than half a bit
    saw_busy = 1'b0;
    for (int n = 0; n <= 12; n++) begin
      if (n == 0) bus.UxRX = 1'b0;
      if (n == 4) bus.UxRX = 1'b1;
      if (bus.busy) saw_busy = 1'b1;
      if (n == 12) chk("glitch_busy_end", 32'(bus.busy), 32'h0);
      @(negedge clk);
    end
    chk("glitch_saw_busy", 32'(saw_busy), 32'h1);
    chk("glitch_rxif", 32'(bus.UxRXIF), 32'h0);
    idle(20);

    // Framing error still delivers the byte
    send_frame(8'hA3, 1'b0, 1'b0, OVS, DONE_AT, 1'b0, -1, -1);
    chk("ferr_data", 32'(bus.rx_data), 32'hA3);
    chk("ferr_flag", 32'(bus.FERR), 32'h1);
    idle(20);
    do_rd();
    chk("ferr_rd_rxif", 32'(bus.UxRXIF), 32'h0);
    chk("ferr_rd_ferr", 32'(bus.FERR), 32'h0);
    idle(20);

    // Read on the completion cycle, then a true overrun
    send_frame(8'h12, 1'b1, 1'b0, OVS, DONE_AT, 1'b0, -1, -1);
    idle(20);
    send_frame(8'h34, 1'b1, 1'b0, OVS, DONE_AT, 1'b1, -1, -1);
    chk("rdsame_data", 32'(bus.rx_data), 32'h34);
    chk("rdsame_rxif", 32'(bus.UxRXIF), 32'h1);
    chk("rdsame_oerr", 32'(bus.OERR), 32'h0);
    idle(20);
    send_frame(8'h56, 1'b1, 1'b0, OVS, DONE_AT, 1'b0, -1, -1);
    chk("ovr_oerr", 32'(bus.OERR), 32'h1);
    chk("ovr_data", 32'(bus.rx_data), 32'h34);
    idle(20);
    do_rd();
    idle(10);

    // Auto-baud aborts mid-data and blocks new starts
    send_frame(8'hF0, 1'b1, 1'b0, OVS, -1, 1'b0, 60, -1);
    chk("abaud_hold_busy", 32'(bus.busy), 32'h0);
    chk("abaud_rxif", 32'(bus.UxRXIF), 32'h0);
    idle(5);
    bus.ABAUD = 1'b0;
    idle(10);
    send_frame(8'h0F, 1'b1, 1'b0, OVS, DONE_AT, 1'b0, -1, -1);
    chk("abaud_after_data", 32'(bus.rx_data), 32'h0F);
    idle(20);

    // Reset mid-frame discards everything, sticky OERR included
    send_frame(8'hF0, 1'b1, 1'b0, OVS, -1, 1'b0, -1, 84);
    chk("rst_rxif", 32'(bus.UxRXIF), 32'h0);
    chk("rst_oerr", 32'(bus.OERR), 32'h0);
    idle(20);

    // Prescaled tick: one tick per 4 cycles, 64-cycle bits
    presc = 1'b1;
    idle(8);
    mdl_on = 1'b0;
    send_frame(8'hC9, 1'b1, 1'b0, 4 * OVS, -1, 1'b0, -1, -1);
    idle(8);
    mdl_frame(8'hC9, 1'b1, 1'b0, 1'b0);
    mdl_on = 1'b1;
    idle(2);
    chk("presc_data", 32'(bus.rx_data), 32'hC9);
    chk("presc_rxif", 32'(bus.UxRXIF), 32'h1);
`ifdef UART_RX_PARITY_EN
    do_rd();
    idle(8);
    mdl_on = 1'b0;
    send_frame(8'hC9, 1'b1, 1'b1, 4 * OVS, -1, 1'b0, -1, -1);
    idle(8);
    mdl_frame(8'hC9, 1'b1, 1'b1, 1'b0);
    mdl_on = 1'b1;
    idle(2);
    chk("parity_perr", 32'(bus.PERR), 32'h1);
`endif
    idle(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
